// File: rtl/sram_banked_pkg.sv
// Shared types and helpers for the banked SRAM controller and its bank arrays.
package sram_banked_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  // Number of byte lanes in a data word.
  function automatic int strb_width(input int dbits);
    return dbits / 8;
  endfunction

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_bank_array.sv
// One synchronous single-port RAM bank with per-lane write enables and a
// registered read port (data appears the cycle after the read).
module sram_bank_array #(
  parameter int abits  = 14,
  parameter int width  = 64,
  parameter int nlanes = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [nlanes-1:0] be,
  input  logic [abits-1:0]  addr,
  input  logic [width-1:0]  wdata,
  output logic [width-1:0]  rdata
);

  localparam int lane_w = width / nlanes;

  logic [width-1:0] mem [0:(1<<abits)-1];

  // NOTE: the array and its read register have no reset; a reset would turn
  // the RAM into flops, and contents are cleared by the controller instead.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < nlanes; i++) begin
          if (be[i]) mem[addr][i*lane_w +: lane_w] <= wdata[i*lane_w +: lane_w];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/sram_banked_ctrl.sv
// Banked internal SRAM with hardware zero-fill and a valid/ready request port.
// Define SRAM_PARITY_EN to store and check one even-parity bit per byte.
module sram_banked_ctrl
  import sram_banked_pkg::*;
#(
  parameter int log2_size     = 18,
  parameter int dbits         = 64,
  parameter int log2_nbanks   = 1,
  parameter int init_on_reset = 1
) (
  input  logic                       i_clk,
  input  logic                       i_nrst,
  input  logic                       i_clear,
  output logic                       o_busy,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_write,
  input  logic [log2_size-1:0]       i_req_addr,
  input  logic [dbits-1:0]           i_req_wdata,
  input  logic [strb_width(dbits)-1:0] i_req_wstrb,
  output logic                       o_resp_valid,
  output logic [dbits-1:0]           o_resp_rdata,
  output logic                       o_resp_err
);

  localparam int nbytes    = strb_width(dbits);
  localparam int wbits     = $clog2(nbytes);
  localparam int nbanks    = 1 << log2_nbanks;
  localparam int bank_w    = (log2_nbanks > 0) ? log2_nbanks : 1;
  localparam int word_bits = log2_size - wbits;
  localparam int row_bits  = word_bits - log2_nbanks;
`ifdef SRAM_PARITY_EN
  localparam int lane_w    = 9;
`else
  localparam int lane_w    = 8;
`endif
  localparam int arr_w     = nbytes * lane_w;

  state_e               state;
  logic [row_bits-1:0]  cnt;
  logic                 accept;
  logic [word_bits-1:0] word_idx;
  logic [row_bits-1:0]  req_row;
  logic [bank_w-1:0]    req_bank;
  logic [arr_w-1:0]     req_word;

  logic [nbanks-1:0]    bank_en;
  logic                 bank_we;
  logic [nbytes-1:0]    bank_be;
  logic [row_bits-1:0]  bank_addr;
  logic [arr_w-1:0]     bank_wdata;
  logic [arr_w-1:0]     bank_rdata [nbanks];

  logic                 rd_pending;
  logic [bank_w-1:0]    rd_bank;
  logic [arr_w-1:0]     rd_word;
  logic [dbits-1:0]     rd_data;
  logic                 par_err;

  assign accept   = i_req_valid & o_req_ready;
  assign word_idx = word_bits'(i_req_addr >> wbits);
  assign req_row  = row_bits'(word_idx >> log2_nbanks);
  assign req_bank = (nbanks == 1) ? '0 : bank_w'(word_idx);

  // Each byte lane is stored as {parity, byte} when parity is built in.
  always_comb begin
    req_word = '0;
    for (int i = 0; i < nbytes; i++) begin
      req_word[i*lane_w +: 8] = i_req_wdata[i*8 +: 8];
`ifdef SRAM_PARITY_EN
      req_word[i*lane_w + 8]  = byte_parity(i_req_wdata[i*8 +: 8]);
`endif
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    bank_en    = '0;
    bank_we    = 1'b0;
    bank_be    = '0;
    bank_addr  = req_row;
    bank_wdata = req_word;
    if (state == ST_INIT) begin
      // Zero-fill hits the same row in every bank at once; zero data has
      // zero parity, so the stored word is all zeros in both builds.
      bank_en    = '1;
      bank_we    = 1'b1;
      bank_be    = '1;
      bank_addr  = cnt;
      bank_wdata = '0;
    end else if (accept) begin
      bank_en[req_bank] = 1'b1;
      bank_we           = i_req_write;
      bank_be           = i_req_wstrb;
    end
  end

  for (genvar b = 0; b < nbanks; b++) begin : g_bank
    sram_bank_array #(
      .abits  (row_bits),
      .width  (arr_w),
      .nlanes (nbytes)
    ) u_bank (
      .clk   (i_clk),
      .en    (bank_en[b]),
      .we    (bank_we),
      .be    (bank_be),
      .addr  (bank_addr),
      .wdata (bank_wdata),
      .rdata (bank_rdata[b])
    );
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // branch sees the pre-edge values of state and cnt.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= (init_on_reset != 0) ? ST_INIT : ST_IDLE;
      cnt         <= '0;
      o_busy      <= (init_on_reset != 0);
      o_req_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (i_clear) begin
            cnt <= '0;
          end else if (&cnt) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            o_busy      <= 1'b0;
            o_req_ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          // A request accepted alongside the clear still completes; the fill
          // starts on the following cycle.
          if (i_clear) begin
            state       <= ST_INIT;
            cnt         <= '0;
            o_busy      <= 1'b1;
            o_req_ready <= 1'b0;
          end else begin
            o_req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      o_resp_valid <= 1'b0;
      rd_pending   <= 1'b0;
      rd_bank      <= '0;
    end else begin
      o_resp_valid <= accept;
      rd_pending   <= accept & ~i_req_write;
      rd_bank      <= req_bank;
    end
  end

  // Read data comes straight from the bank output register, so the response
  // lands exactly one cycle after acceptance.
  always_comb begin
    rd_word = bank_rdata[rd_bank];
    rd_data = '0;
    par_err = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      rd_data[i*8 +: 8] = rd_word[i*lane_w +: 8];
`ifdef SRAM_PARITY_EN
      par_err = par_err | (byte_parity(rd_word[i*lane_w +: 8]) != rd_word[i*lane_w + 8]);
`endif
    end
    o_resp_rdata = rd_pending ? rd_data : '0;
    o_resp_err   = rd_pending & par_err;
  end

endmodule
